// File: rtl/store_monitor_if.sv
// Store-monitor bus: processor store port in, FIFO readout and status out.
// The slave modport is the monitor itself; the master modport is its observer/driver.
interface store_monitor_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          memwrite;
    logic [31:0]   dataadr;
    logic [31:0]   writedata;
    logic          rd_en;
    logic          rd_valid;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_data;
    logic [CW-1:0] count;
    logic          overflow;
    logic          done;
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [31:0]   cycle_count;

    modport master (
        output memwrite, dataadr, writedata, rd_en,
        input  rd_valid, rd_addr, rd_data, count, overflow,
               done, pass, fail, timeout, cycle_count
    );

    modport slave (
        input  memwrite, dataadr, writedata, rd_en,
        output rd_valid, rd_addr, rd_data, count, overflow,
               done, pass, fail, timeout, cycle_count
    );
endinterface

// File: rtl/store_monitor.sv
// Observes processor data-memory stores: captures them in a FWFT FIFO and
// decides pass/fail/timeout from the program-completion store or a cycle budget.
module store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DONE_ADDR = 32'd84,
    parameter logic [31:0] DONE_DATA = 32'd7,
    parameter logic [31:0] TIMEOUT   = 32'd25
) (
    input  logic           clk,
    input  logic           reset,
    store_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

    state_t        r_state;
    logic [31:0]   r_mem_addr [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_done;
    logic          r_pass;
    logic          r_fail;
    logic          r_timeout;
    logic [31:0]   r_cycle_count;

    logic w_run;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_drop;
    logic w_done_store;

    assign w_run        = (r_state == ST_RUN);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_pop        = bus.rd_en && !w_empty;
    assign w_push_req   = w_run && bus.memwrite;
    // A full FIFO still accepts a store when the head leaves on the same edge.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_drop       = w_push_req && w_full && !w_pop;
    assign w_done_store = w_push_req && (bus.dataadr == DONE_ADDR);

    // NOTE: storage array has no reset; contents are masked by r_count, and
    // leaving it unreset lets it map onto plain RAM/flops without reset routing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= bus.dataadr;
            r_mem_data[r_wr_ptr] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cycle_count <= r_cycle_count + 32'd1;
                    // The completion store outranks a budget expiring on the same edge.
                    if (w_done_store) begin
                        r_done <= 1'b1;
                        if (bus.writedata == DONE_DATA) begin
                            r_state <= ST_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (r_cycle_count == TIMEOUT - 32'd1) begin
                        r_state   <= ST_TIMEOUT;
                        r_done    <= 1'b1;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign bus.rd_valid    = !w_empty;
    assign bus.rd_addr     = w_empty ? 32'd0 : r_mem_addr[r_rd_ptr];
    assign bus.rd_data     = w_empty ? 32'd0 : r_mem_data[r_rd_ptr];
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: a queue-based model is checked on every
// falling edge, and literal expectations pin the model at key points.
module tb_store_monitor;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 25;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    store_monitor_if #(.DEPTH(DEPTH)) bus ();

    store_monitor #(
        .DEPTH    (DEPTH),
        .DONE_ADDR(32'd84),
        .DONE_DATA(32'd7),
        .TIMEOUT  (32'(TIMEOUT))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: stored entries plus the terminal verdict.
    logic [63:0] m_q[$];
    bit          m_ovf  = 1'b0;
    bit          m_done = 1'b0;
    bit          m_pass = 1'b0;
    bit          m_fail = 1'b0;
    bit          m_to   = 1'b0;
    int          m_cyc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_pass = 1'b0;
        m_fail = 1'b0;
        m_to   = 1'b0;
        m_cyc  = 0;
    endtask

    // Applies one rising edge's worth of rules to the model, using the held inputs.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        int old_cyc;
        do_pop  = bus.rd_en && (m_q.size() > 0);
        do_push = 1'b0;
        if (!m_done) begin
            old_cyc = m_cyc;
            m_cyc++;
            if (bus.memwrite) begin
                if (m_q.size() == DEPTH && !do_pop) m_ovf = 1'b1;
                else                                do_push = 1'b1;
                if (bus.dataadr == 32'd84) begin
                    m_done = 1'b1;
                    if (bus.writedata == 32'd7) m_pass = 1'b1;
                    else                        m_fail = 1'b1;
                end
            end
            if (!m_done && old_cyc == TIMEOUT - 1) begin
                m_done = 1'b1;
                m_fail = 1'b1;
                m_to   = 1'b1;
            end
        end
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back({bus.dataadr, bus.writedata});
    endtask

    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic re);
        bus.memwrite  = mw;
        bus.dataadr   = a;
        bus.writedata = d;
        bus.rd_en     = re;
        @(posedge clk);
        model_step();
        #1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'd0;
        bus.writedata = 32'd0;
        bus.rd_en     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        check("rd_valid",    32'(bus.rd_valid), 32'(m_q.size() != 0));
        check("rd_addr",     bus.rd_addr, (m_q.size() != 0) ? m_q[0][63:32] : 32'd0);
        check("rd_data",     bus.rd_data, (m_q.size() != 0) ? m_q[0][31:0]  : 32'd0);
        check("count",       32'(bus.count), 32'(m_q.size()));
        check("overflow",    32'(bus.overflow), 32'(m_ovf));
        check("done",        32'(bus.done), 32'(m_done));
        check("pass",        32'(bus.pass), 32'(m_pass));
        check("fail",        32'(bus.fail), 32'(m_fail));
        check("timeout",     32'(bus.timeout), 32'(m_to));
        check("cycle_count", bus.cycle_count, 32'(m_cyc));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'd0;
        bus.writedata = 32'd0;
        bus.rd_en     = 1'b0;
        #1;
        do_reset();
        check("t0 count",    32'(bus.count), 32'd0);
        check("t0 rd_valid", 32'(bus.rd_valid), 32'd0);
        check("t0 done",     32'(bus.done), 32'd0);

        // 1: single store, FWFT readout, pop, pop on empty
        step(1'b1, 32'h10, 32'h5, 1'b0);
        check("t1 rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t1 rd_addr",  bus.rd_addr, 32'h10);
        check("t1 rd_data",  bus.rd_data, 32'h5);
        check("t1 count",    32'(bus.count), 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        check("t1 pop valid", 32'(bus.rd_valid), 32'd0);
        check("t1 pop count", 32'(bus.count), 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        check("t1 underflow count", 32'(bus.count), 32'd0);
        check("t1 cycle_count", bus.cycle_count, 32'd3);

        // 2: pass, then post-termination store ignored, drain after done
        do_reset();
        step(1'b1, 32'h50, 32'h11, 1'b0);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        check("t2 done",  32'(bus.done), 32'd1);
        check("t2 pass",  32'(bus.pass), 32'd1);
        check("t2 fail",  32'(bus.fail), 32'd0);
        check("t2 count", 32'(bus.count), 32'd2);
        step(1'b1, 32'h60, 32'h22, 1'b0);
        check("t2 late count", 32'(bus.count), 32'd2);
        check("t2 cyc frozen", bus.cycle_count, 32'd2);
        check("t2 no ovf",     32'(bus.overflow), 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        check("t2 drain head", bus.rd_addr, 32'd84);

        // 3: completion store with wrong data
        do_reset();
        step(1'b1, 32'd84, 32'd3, 1'b0);
        check("t3 done",    32'(bus.done), 32'd1);
        check("t3 fail",    32'(bus.fail), 32'd1);
        check("t3 pass",    32'(bus.pass), 32'd0);
        check("t3 timeout", 32'(bus.timeout), 32'd0);

        // 4: nine stores into eight entries, then drain in order
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 32'(i * 4), 32'(100 + i), 1'b0);
            if (i == 8) check("t4 ovf before", 32'(bus.overflow), 32'd0);
        end
        check("t4 count", 32'(bus.count), 32'd8);
        check("t4 ovf",   32'(bus.overflow), 32'd1);
        check("t4 head",  bus.rd_addr, 32'd4);
        for (int i = 1; i <= 8; i++) begin
            check("t4 pop addr", bus.rd_addr, 32'(i * 4));
            check("t4 pop data", bus.rd_data, 32'(100 + i));
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        check("t4 empty", 32'(bus.rd_valid), 32'd0);

        // 5: full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 32'(i + 32'h100), 1'b0);
        step(1'b1, 32'h99, 32'hAB, 1'b1);
        check("t5 count", 32'(bus.count), 32'd8);
        check("t5 ovf",   32'(bus.overflow), 32'd0);
        check("t5 head",  bus.rd_addr, 32'd2);
        for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
        check("t5 newest addr", bus.rd_addr, 32'h99);
        check("t5 newest data", bus.rd_data, 32'hAB);

        // 6a: budget expires after 25 edges
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
        check("t6 pre done", 32'(bus.done), 32'd0);
        check("t6 pre cyc",  bus.cycle_count, 32'd24);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        check("t6 done",    32'(bus.done), 32'd1);
        check("t6 fail",    32'(bus.fail), 32'd1);
        check("t6 timeout", 32'(bus.timeout), 32'd1);
        check("t6 cyc",     bus.cycle_count, 32'd25);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        check("t6 cyc frozen", bus.cycle_count, 32'd25);

        // 6b: completion store on the expiring edge wins
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        check("t6b pass",    32'(bus.pass), 32'd1);
        check("t6b timeout", 32'(bus.timeout), 32'd0);
        check("t6b fail",    32'(bus.fail), 32'd0);
        check("t6b count",   32'(bus.count), 32'd1);

        // 7: asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i + 32'h200), 32'(i), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
        check("t7 pre count", 32'(bus.count), 32'd3);
        check("t7 pre cyc",   bus.cycle_count, 32'd10);
        reset = 1'b0;
        model_clear();
        #1;
        check("t7 async count", 32'(bus.count), 32'd0);
        check("t7 async valid", 32'(bus.rd_valid), 32'd0);
        check("t7 async cyc",   bus.cycle_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 32'h300, 32'h33, 1'b0);
        check("t7 resume count", 32'(bus.count), 32'd1);
        check("t7 resume cyc",   bus.cycle_count, 32'd1);
        check("t7 resume addr",  bus.rd_addr, 32'h300);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
Downstream observer of the pipelined MIPS top-level data-memory write port (memwrite, dataadr, writedata). It captures every store into a small first-word-fall-through FIFO for bench or debug readout and detects the program-completion store to raise pass or fail. A cycle-budget counter flags runaway programs. It replaces ad-hoc clock counting in processor benches and stays synthesizable for on-board debug.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
DONE_ADDR, 32'd84, store address that terminates the program.
DONE_DATA, 32'd7, value at DONE_ADDR that means pass.
TIMEOUT, 32'd25, cycle budget in RUN before the block declares timeout; at least 1.

Ports:
clk  in  1  Single clock; all state updates on rising edge.
reset  in  1  Asynchronous, active-low reset (0 = reset asserted).
memwrite  in  1  Store strobe from processor.
dataadr  in  32  Store address from processor.
writedata  in  32  Store data from processor.
rd_en  in  1  Pop request for the FIFO head.
rd_valid  out  1  FIFO non-empty; head is valid.
rd_addr  out  32  Head entry address.
rd_data  out  32  Head entry data.
count  out  $clog2(DEPTH)+1  Number of occupied FIFO entries.
overflow  out  1  Sticky; a store was dropped because the FIFO was full.
done  out  1  Sticky; the block has reached a terminal state.
pass  out  1  Sticky; the done store carried DONE_DATA.
fail  out  1  Sticky; the done store carried another value, or timeout fired.
timeout  out  1  Sticky; the cycle budget expired.
cycle_count  out  32  Cycles spent in RUN.

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied, count=0, rd_valid=0, rd_addr=rd_data=0 when empty. overflow, done, pass, fail and timeout are 0. cycle_count=0 and state=RUN. Asserting reset mid-operation aborts everything immediately; there is no partial retention.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are absorbing until reset.
- done=1 in PASS, FAIL and TIMEOUT. pass=1 only in PASS. fail=1 in FAIL and TIMEOUT. timeout=1 only in TIMEOUT.
- Capture happens only in RUN. On a rising edge with memwrite=1, {dataadr, writedata} is pushed. The entry is visible on rd_* one cycle later (1-cycle latency).
- Push when full:
  - With a simultaneous valid pop, the push succeeds and count stays the same.
  - Without a pop, the store is dropped and overflow is set.
- Pop: rd_en=1 with rd_valid=1 advances the head at the edge. rd_en while empty is ignored with no underflow. Pops remain allowed in every state, so the FIFO drains after termination.
- Push and pop on the same edge when non-empty leave count unchanged. Pointers wrap modulo DEPTH.
- Done detection (RUN only): memwrite=1 and dataadr==DONE_ADDR causes a transition on that edge.
  - writedata==DONE_DATA -> PASS.
  - Any other value -> FAIL.
  - The done store itself is also pushed, subject to the full rule.
- cycle_count increments by 1 each edge while in RUN and freezes in terminal states.
- Timeout: if in RUN with cycle_count==TIMEOUT-1 and no done store that edge -> TIMEOUT. If a done store arrives on that same edge, the done store wins (PASS or FAIL) and timeout stays 0.
- Stores after termination are ignored and do not set overflow.
- All outputs are registered or derived directly from registers; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, single store memwrite=1, dataadr=0x10, writedata=0x5 for one cycle -> next cycle rd_valid=1, rd_addr=0x10, rd_data=0x5, count=1. Pulse rd_en -> rd_valid=0, count=0.
2. Stores to 0x50 then 84 with data 7 -> done=pass=1, fail=0, count=2. A later store to 0x60 is not captured. cycle_count frozen.
3. Store to 84 with data 3 -> done=fail=1, pass=0, timeout=0.
4. Nine consecutive stores (DEPTH=8) with no pops -> count=8, overflow=1, and the head is the first store. Then 8 pops return stores 1-8 in order.
5. FIFO full, then push and pop on the same cycle -> count stays 8, overflow=0, and the newest entry is stored.
6. No done store, TIMEOUT=25 -> after 25 edges: done=fail=timeout=1, cycle_count=25. Repeat with the done store (data 7) on edge 25 -> pass=1, timeout=0.
7. Reset asserted mid-run with count=3 and cycle_count=10 -> immediately count=0, rd_valid=0, all flags 0. Release -> capture resumes from cycle_count=0.
